// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter: opcode encodings and the
// arbiter FSM state type.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_INC  = 5'd8;
  localparam logic [4:0] OP_DEC  = 5'd9;
  localparam logic [4:0] OP_LAST = OP_DEC;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 19-bit ALU. Results truncate to DATA_W; divide by zero
// saturates to all-ones and raises div_by_zero; unknown opcodes return 0.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 19,
  parameter int OP_W   = 5
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              div_by_zero
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    case (opcode)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_MUL: result = a * b;
      OP_DIV: begin
        if (b == '0) begin
          result      = '1;
          div_by_zero = 1'b1;
        end else begin
          result = a / b;
        end
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_INC: result = a + 1'b1;
      OP_DEC: result = a - 1'b1;
      default: result = '0;
    endcase
  end

  assign zero_flag = (result == '0);

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin select: first asserted request at or after ptr,
// wrapping modulo N. Produces a one-hot grant and its binary index.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found                      = 1'b1;
        grant[(int'(ptr) + i) % N] = 1'b1;
        idx                        = IDX_W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu among NUM_REQ requesters, one operation
// in flight. Define ALU_ARB_ILLEGAL_TRAP_EN to trap opcodes above OP_LAST.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 19,
  parameter int OP_W    = 5,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_opcode,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_dbz,
  output logic                      rsp_err
);

  arb_state_e        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_idx;

  logic [OP_W-1:0]   op_code;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [ID_W-1:0]   op_id;

  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_dbz;

  rr_picker #(.N(NUM_REQ), .IDX_W(ID_W)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .opcode      (op_code),
    .a           (op_a),
    .b           (op_b),
    .result      (alu_result),
    .zero_flag   (alu_zero),
    .div_by_zero (alu_dbz)
  );

  // Grant is offered combinationally so a request is accepted in its first
  // IDLE cycle; masked during reset so nothing is accepted and then discarded.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      op_code    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_dbz    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            op_code <= req_opcode[grant_idx*OP_W +: OP_W];
            op_a    <= req_a[grant_idx*DATA_W +: DATA_W];
            op_b    <= req_b[grant_idx*DATA_W +: DATA_W];
            op_id   <= grant_idx;
            rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= op_id;
`ifdef ALU_ARB_ILLEGAL_TRAP_EN
          if (op_code > OP_W'(OP_LAST)) begin
            rsp_result <= '1;
            rsp_zero   <= 1'b0;
            rsp_dbz    <= 1'b0;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_dbz    <= alu_dbz;
            rsp_err    <= 1'b0;
          end
`else
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_dbz    <= alu_dbz;
          rsp_err    <= 1'b0;
`endif
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a scoreboard of expected responses,
// checked by immediate assertions. Honours ALU_ARB_ILLEGAL_TRAP_EN.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 4;
  localparam int DW = 19;
  localparam int OW = 5;
  localparam int IW = 2;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] result;
    logic          zero;
    logic          dbz;
    logic          err;
  } rsp_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*OW-1:0] req_opcode;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_result;
  logic            rsp_zero;
  logic            rsp_dbz;
  logic            rsp_err;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_dbz    (rsp_dbz),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [OW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_opcode[i*OW +: OW] = op;
    req_a[i*DW +: DW]      = a;
    req_b[i*DW +: DW]      = b;
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] res,
                          input logic z, input logic d, input logic e);
    rsp_t r;
    r.id = IW'(id); r.result = res; r.zero = z; r.dbz = d; r.err = e;
    exp_q.push_back(r);
  endtask

  // Called at a negedge where a response is expected to be valid.
  task automatic check_rsp(input string tag);
    rsp_t r;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_qlen"}, exp_q.size(), 32'd1);
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      check({tag, "_id"},     32'(rsp_id),     32'(r.id));
      check({tag, "_result"}, 32'(rsp_result), 32'(r.result));
      check({tag, "_zero"},   32'(rsp_zero),   32'(r.zero));
      check({tag, "_dbz"},    32'(rsp_dbz),    32'(r.dbz));
      check({tag, "_err"},    32'(rsp_err),    32'(r.err));
    end
  endtask

  // Single request from an idle arbiter with rsp_ready high; operands are
  // scrambled right after the handshake to show they were latched.
  task automatic issue(input string tag, input int idx, input logic [OW-1:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    set_req(idx, op, a, b);
    req_valid = N'(1) << idx;
    @(negedge clk);
    check({tag, "_grant"}, 32'(req_ready), 32'(N'(1) << idx));
    tick();
    req_valid  = '0;
    req_opcode = '1;
    req_a      = '1;
    req_b      = '1;
    @(negedge clk);
    check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    tick();
    @(negedge clk);
    check_rsp(tag);
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '1;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_id",     32'(rsp_id),     32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_flags",  {29'd0, rsp_zero, rsp_dbz, rsp_err}, 32'd0);
    req_valid = '0;
    tick();
    rst = 1'b0;

    push_exp(2, 19'd12, 1'b0, 1'b0, 1'b0);
    issue("add_r2", 2, OP_ADD, 19'd5, 19'd7);

    push_exp(1, 19'h7FFFF, 1'b0, 1'b1, 1'b0);
    issue("div0_r1", 1, OP_DIV, 19'd100, 19'd0);

`ifdef ALU_ARB_ILLEGAL_TRAP_EN
    push_exp(3, 19'h7FFFF, 1'b0, 1'b0, 1'b1);
`else
    push_exp(3, 19'd0, 1'b1, 1'b0, 1'b0);
`endif
    issue("illegal_r3", 3, 5'h15, 19'd9, 19'd4);

    push_exp(0, 19'h74240, 1'b0, 1'b0, 1'b0);
    issue("mul_trunc_r0", 0, OP_MUL, 19'd1000, 19'd1000);

    // Full contention from reset: grants must rotate 0,1,2,3,0 every 3 cycles.
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, OP_ADD, DW'(i * 10), 19'd1);
    req_valid = '1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(N'(1) << (k % N)));
      push_exp(k % N, DW'((k % N) * 10 + 1), 1'b0, 1'b0, 1'b0);
      tick();
      @(negedge clk);
      check($sformatf("rr_exec%0d", k), 32'(rsp_valid), 32'd0);
      tick();
      @(negedge clk);
      check_rsp($sformatf("rr_rsp%0d", k));
      tick();
    end
    req_valid = '0;

    // Backpressure: response held stable for 10 cycles, no new grants.
    rsp_ready = 1'b0;
    set_req(0, OP_SUB, 19'd3, 19'd3);
    push_exp(0, 19'd0, 1'b1, 1'b0, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    check("hold_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '1;
    tick();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("hold_valid%0d", k),  32'(rsp_valid),  32'd1);
      check($sformatf("hold_result%0d", k), 32'(rsp_result), 32'd0);
      check($sformatf("hold_zero%0d", k),   32'(rsp_zero),   32'd1);
      check($sformatf("hold_ready%0d", k),  32'(req_ready),  32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check_rsp("hold_rsp");
    tick();
    @(negedge clk);
    check("hold_idle_valid", 32'(rsp_valid), 32'd0);
    tick();

    // Reset during EXEC: MUL is discarded, lowest valid index wins afterwards.
    set_req(2, OP_MUL, 19'd300, 19'd400);
    set_req(1, OP_ADD, 19'd20, 19'd22);
    set_req(3, OP_XOR, 19'd1, 19'd1);
    req_valid = 4'b0100;
    @(negedge clk);
    check("rstx_grant", 32'(req_ready), 32'b0100);
    tick();
    rst       = 1'b1;
    req_valid = 4'b1010;
    @(negedge clk);
    check("rstx_ready_in_rst", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstx_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rstx_rsp_id",     32'(rsp_id),     32'd0);
    check("rstx_rsp_result", 32'(rsp_result), 32'd0);
    check("rstx_rsp_flags",  {29'd0, rsp_zero, rsp_dbz, rsp_err}, 32'd0);
    check("rstx_next_grant", 32'(req_ready),  32'b0010);
    push_exp(1, 19'd42, 1'b0, 1'b0, 1'b0);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("rstx_exec_valid", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check_rsp("rstx_rsp");
    tick();

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
